// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MIPS write-back stage with MEM/WB register, load extraction, GRF/bypass drive and retire counter
module wb_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int LINK_OFS = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       pc_in,
  input  logic              reg_we_in,
  input  logic [RA_W-1:0]   reg_wa_in,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        ld_type_in,
  input  logic [1:0]        addr_lo_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] hilo_in,
  output logic              grf_we,
  output logic [RA_W-1:0]   grf_wa,
  output logic [DATA_W-1:0] grf_wd,
  output logic [31:0]       wb_pc,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_wa,
  output logic [DATA_W-1:0] fwd_wd,
  output logic              align_err,
  output logic [CNT_W-1:0]  retired
);
  localparam logic [2:0] LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4;
  logic              valid, reg_we;
  logic [31:0]       pc;
  logic [RA_W-1:0]   wa;
  logic [1:0]        wb_sel, addr_lo;
  logic [2:0]        ld_type;
  logic [DATA_W-1:0] alu, mem, hilo;
  logic [CNT_W-1:0]  cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      reg_we  <= 1'b0;
      pc      <= '0;
      wa      <= '0;
      wb_sel  <= '0;
      addr_lo <= '0;
      ld_type <= '0;
      alu     <= '0;
      mem     <= '0;
      hilo    <= '0;
      cnt     <= '0;
    end else begin
      if (flush) valid <= 1'b0;
      else if (!stall) begin
        valid   <= in_valid;
        reg_we  <= reg_we_in;
        pc      <= pc_in;
        wa      <= reg_wa_in;
        wb_sel  <= wb_sel_in;
        addr_lo <= addr_lo_in;
        ld_type <= ld_type_in;
        alu     <= alu_in;
        mem     <= mem_in;
        hilo    <= hilo_in;
      end
      if (valid && !stall) cnt <= cnt + 1'b1;
    end
  end
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       link;
  logic [DATA_W-1:0] ld_val, wd;
  logic              is_lw, is_h, err;
  always_comb begin
    ld_b   = 8'(mem >> {addr_lo, 3'b000});
    ld_h   = 16'(mem >> {addr_lo[1], 4'b0000});
    link   = pc + 32'(LINK_OFS);
    ld_val = ld_type == LB  ? {{(DATA_W-8){ld_b[7]}}, ld_b} :
             ld_type == LBU ? {{(DATA_W-8){1'b0}}, ld_b} :
             ld_type == LH  ? {{(DATA_W-16){ld_h[15]}}, ld_h} :
             ld_type == LHU ? {{(DATA_W-16){1'b0}}, ld_h} : mem;
    wd     = wb_sel == 2'd0 ? alu :
             wb_sel == 2'd1 ? ld_val :
             wb_sel == 2'd2 ? DATA_W'(link) : hilo;
    is_lw  = ld_type == 3'd0 || ld_type > LHU;
    is_h   = ld_type == LH || ld_type == LHU;
    err    = valid && wb_sel == 2'd1 && ((is_lw && addr_lo != 2'd0) || (is_h && addr_lo[0]));
  end
  assign align_err = err;
  assign grf_we    = valid && reg_we && wa != '0 && !err;
  assign grf_wa    = wa;
  assign grf_wd    = wd;
  assign fwd_valid = grf_we;
  assign fwd_wa    = wa;
  assign fwd_wd    = wd;
  assign wb_pc     = pc;
  assign retired   = cnt;
endmodule
